// File: rtl/gpr_pkg.sv
// Shared defaults and helpers for the parametrised general-purpose register file.
package gpr_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_NUM_RD  = 2;
    localparam int DEF_OVF_REG = 30;

    localparam int READ_LAT_COMB = 0;
    localparam int READ_LAT_REG  = 1;

    // Low bit of field k in a bus of w-bit fields packed from bit 0 upward.
    function automatic int port_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/gpr_file_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a saturating count of busy registers.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

    logic [DEPTH-1:0] set_vec, clr_vec, busy_nxt;
    logic             inc, dec;
    logic [ADDR_W:0]  cnt_nxt;

    // OR-ing the set after the clear lets a fresh issue survive a same-cycle writeback.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_valid && !(ZERO_REG != 0 && iss_addr == '0))
            set_vec[iss_addr] = 1'b1;
        if (we)
            clr_vec[wr_addr] = 1'b1;
        busy_nxt = (busy & ~clr_vec) | set_vec;
        inc      = |(busy_nxt & ~busy);
        dec      = |(busy & ~busy_nxt);
        cnt_nxt  = pend_cnt;
        if (inc && !dec && pend_cnt != CNT_MAX)
            cnt_nxt = pend_cnt + (ADDR_W+1)'(1);
        else if (dec && !inc && pend_cnt != '0)
            cnt_nxt = pend_cnt - (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/gpr_file_mp.sv
// Parametrised register file: N read ports, optional bypass or registered reads,
// sticky overflow status and a pending-write scoreboard.
module gpr_file_mp
    import gpr_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int OVF_REG  = DEF_OVF_REG,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = READ_LAT_COMB
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     overflow,
    input  logic                     ovf_clr,
    output logic                     ovf_flag,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] OVF_IDX = ADDR_W'(OVF_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_ok, wr_norm, ovf_set;

    assign wr_ok   = !(ZERO_REG != 0 && wr_addr == '0);
    assign wr_norm = we && !overflow && wr_ok;
    assign ovf_set = we && overflow;

    // Statement order encodes priority: clear < normal write data < overflow set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (ovf_clr) begin
                regs[OVF_IDX][0] <= 1'b0;
                ovf_flag         <= 1'b0;
            end
            if (wr_norm)
                regs[wr_addr] <= wr_data;
            if (ovf_set) begin
                regs[OVF_IDX][0] <= 1'b1;
                ovf_flag         <= 1'b1;
            end
        end
    end

    gpr_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .reset_n   (reset_n),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .we        (we),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .pend_cnt  (pend_cnt)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr       = rd_addr[port_lo(k, ADDR_W) +: ADDR_W];
        assign rd_busy[k] = busy[addr];

        if (READ_LAT == READ_LAT_REG) begin : g_reg
            logic [DATA_W-1:0] nxt, rd_p1;
            // Mirror the storage update so the registered read is write-first.
            always_comb begin
                nxt = regs[addr];
                if (ovf_clr && addr == OVF_IDX) nxt[0] = 1'b0;
                if (wr_norm && addr == wr_addr) nxt = wr_data;
                if (ovf_set && addr == OVF_IDX) nxt[0] = 1'b1;
                if (ZERO_REG != 0 && addr == '0) nxt = '0;
            end
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) rd_p1 <= '0;
                else          rd_p1 <= nxt;
            end
            assign rd_data[port_lo(k, DATA_W) +: DATA_W] = rd_p1;
        end else begin : g_comb
            logic [DATA_W-1:0] cur;
            always_comb begin
                cur = regs[addr];
                if (BYPASS != 0 && wr_norm && addr == wr_addr) cur = wr_data;
                if (ZERO_REG != 0 && addr == '0) cur = '0;
            end
            assign rd_data[port_lo(k, DATA_W) +: DATA_W] = cur;
        end
    end

endmodule
